// File: rtl/zube_bus_arbiter.sv
// Arbiter/sequencer for the zube mailbox register file: serialises Wishbone and
// external-host accesses round-robin and generates the doorbell interrupts.
module zube_bus_arbiter (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        wb_cyc_in,
    input  logic        wb_stb_in,
    input  logic        wb_we_in,
    input  logic [31:0] wb_addr_in,
    input  logic [31:0] wb_data_in,
    output logic        wb_ack_out,
    output logic [31:0] wb_data_out,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [2:0]  ext_addr,
    input  logic [7:0]  ext_wdata,
    output logic        ext_ack,
    output logic [7:0]  ext_rdata,
    output logic        rf_en,
    output logic        rf_we,
    output logic [2:0]  rf_addr,
    output logic [7:0]  rf_wdata,
    input  logic [7:0]  rf_rdata,
    output logic        irq_out,
    output logic        ext_irq_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESPOND} state_t;
    typedef enum logic {SIDE_WB, SIDE_EXT} side_t;

    state_t     state;
    side_t      grant;
    side_t      last_grant;
    logic       access_we;
    logic [7:0] wb_byte;
    logic [7:0] ext_byte;
    logic       wb_req;
    logic       pick_ext;
    logic [7:0] resp_byte;
    logic       wb_responding;
    logic       ext_responding;
    logic       unused_bus_bits;

    assign wb_req   = wb_cyc_in & wb_stb_in;
    // On a tie the side that was not served last wins.
    assign pick_ext = ext_req & (~wb_req | (last_grant == SIDE_WB));

    assign resp_byte      = access_we ? rf_wdata : rf_rdata;
    assign wb_responding  = (state == ST_RESPOND) && (grant == SIDE_WB);
    assign ext_responding = (state == ST_RESPOND) && (grant == SIDE_EXT);

    // rf_rdata only arrives during RESPOND, so the byte is forwarded while the
    // ack is high and held in wb_byte/ext_byte afterwards.
    assign wb_data_out = {24'b0, wb_responding ? resp_byte : wb_byte};
    assign ext_rdata   = ext_responding ? resp_byte : ext_byte;

    assign unused_bus_bits = ^{wb_addr_in[31:5], wb_addr_in[1:0], wb_data_in[31:8]};

    // NOTE: reset is synchronous, so it lives inside the clocked branch and every
    // state element uses non-blocking assignment to avoid ordering races.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state       <= ST_IDLE;
            grant       <= SIDE_WB;
            last_grant  <= SIDE_EXT;
            access_we   <= 1'b0;
            rf_en       <= 1'b0;
            rf_we       <= 1'b0;
            rf_addr     <= 3'd0;
            rf_wdata    <= 8'd0;
            wb_ack_out  <= 1'b0;
            ext_ack     <= 1'b0;
            wb_byte     <= 8'd0;
            ext_byte    <= 8'd0;
            irq_out     <= 1'b0;
            ext_irq_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wb_req || ext_req) begin
                        grant      <= pick_ext ? SIDE_EXT : SIDE_WB;
                        last_grant <= pick_ext ? SIDE_EXT : SIDE_WB;
                        rf_en      <= 1'b1;
                        if (pick_ext) begin
                            rf_we     <= ext_we;
                            access_we <= ext_we;
                            rf_addr   <= ext_addr;
                            rf_wdata  <= ext_wdata;
                        end else begin
                            rf_we     <= wb_we_in;
                            access_we <= wb_we_in;
                            rf_addr   <= wb_addr_in[4:2];
                            rf_wdata  <= wb_data_in[7:0];
                        end
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rf_en <= 1'b0;
                    rf_we <= 1'b0;
                    if (grant == SIDE_WB) wb_ack_out <= 1'b1;
                    else                  ext_ack    <= 1'b1;
                    state <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    wb_ack_out <= 1'b0;
                    ext_ack    <= 1'b0;
                    if (grant == SIDE_WB) wb_byte  <= resp_byte;
                    else                  ext_byte <= resp_byte;
                    // Doorbells: EXT write of 7 rings the SoC, WB read of 7 clears it;
                    // WB write of 6 rings the host, EXT read of 6 clears it.
                    if (grant == SIDE_EXT && access_we && rf_addr == 3'd7)
                        irq_out <= 1'b1;
                    else if (grant == SIDE_WB && !access_we && rf_addr == 3'd7)
                        irq_out <= 1'b0;
                    if (grant == SIDE_WB && access_we && rf_addr == 3'd6)
                        ext_irq_out <= 1'b1;
                    else if (grant == SIDE_EXT && !access_we && rf_addr == 3'd6)
                        ext_irq_out <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zube_bus_arbiter.sv
// Self-checking bench for zube_bus_arbiter: behavioural register file, ack
// scoreboard, table-driven single accesses and hand-written arbitration sequences.
module tb_zube_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        wb_cyc_in, wb_stb_in, wb_we_in;
    logic [31:0] wb_addr_in, wb_data_in;
    logic        wb_ack_out;
    logic [31:0] wb_data_out;
    logic        ext_req, ext_we;
    logic [2:0]  ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_ack;
    logic [7:0]  ext_rdata;
    logic        rf_en, rf_we;
    logic [2:0]  rf_addr;
    logic [7:0]  rf_wdata;
    logic [7:0]  rf_rdata;
    logic        irq_out, ext_irq_out;

    always #5 clk = ~clk;

    zube_bus_arbiter dut (
        .clk(clk), .reset_b(reset_b),
        .wb_cyc_in(wb_cyc_in), .wb_stb_in(wb_stb_in), .wb_we_in(wb_we_in),
        .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
        .wb_ack_out(wb_ack_out), .wb_data_out(wb_data_out),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata),
        .irq_out(irq_out), .ext_irq_out(ext_irq_out)
    );

    // Synchronous-read register file: data valid the cycle after rf_en.
    logic [7:0] mem [8];
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'd0;
        rf_rdata = 8'd0;
    end
    always @(posedge clk) begin
        if (rf_en) begin
            if (rf_we) mem[rf_addr] <= rf_wdata;
            rf_rdata <= mem[rf_addr];
        end
    end

    typedef struct { logic is_ext; logic [7:0] data; } sb_t;
    typedef struct {
        logic        is_ext;
        logic        we;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_data;
        logic        exp_irq;
        logic        exp_ext_irq;
    } vec_t;

    sb_t sb [$];
    int  checks = 0;
    int  errors = 0;
    int  cyc_cnt = 0;
    int  a1, a2, t0;
    int  ext_at [6];
    int  wb_at  [6];
    vec_t vecs [11];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Ack monitor: pops the scoreboard and checks the one-hot/no-back-to-back rules.
    logic prev_rf_en = 1'b0, prev_ack = 1'b0;
    always @(negedge clk) begin
        sb_t e;
        if (wb_ack_out || ext_ack) begin
            check("ack_overlap", 32'(wb_ack_out & ext_ack), 0);
            check("ack_b2b", 32'(prev_ack), 0);
            if (sb.size() == 0) check("unexpected_ack", 1, 0);
            else begin
                e = sb.pop_front();
                check("ack_side", 32'(ext_ack), 32'(e.is_ext));
                check("ack_data", ext_ack ? {24'b0, ext_rdata} : wb_data_out, {24'b0, e.data});
            end
        end
        if (rf_en) check("rf_en_b2b", 32'(prev_rf_en), 0);
        if (rf_we) check("rf_we_without_en", 32'(rf_en), 1);
        prev_rf_en <= rf_en;
        prev_ack   <= wb_ack_out | ext_ack;
    end

    task automatic wb_access(input logic we, input logic [31:0] addr, input logic [7:0] data,
                             output int ack_at);
        logic [23:0] junk;
        junk       = 24'($urandom);
        ack_at     = -1;
        wb_cyc_in  = 1'b1;
        wb_stb_in  = 1'b1;
        wb_we_in   = we;
        wb_addr_in = addr;
        wb_data_in = {junk, data};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wb_ack_out) begin
                ack_at = cyc_cnt;
                break;
            end
        end
        wb_cyc_in = 1'b0;
        wb_stb_in = 1'b0;
        if (ack_at < 0) check("wb_ack_timeout", 0, 1);
    endtask

    task automatic ext_access(input logic we, input logic [2:0] addr, input logic [7:0] data,
                              output int ack_at);
        ack_at    = -1;
        ext_req   = 1'b1;
        ext_we    = we;
        ext_addr  = addr;
        ext_wdata = data;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ext_ack) begin
                ack_at = cyc_cnt;
                break;
            end
        end
        ext_req = 1'b0;
        if (ack_at < 0) check("ext_ack_timeout", 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rf_en"},       32'(rf_en), 0);
        check({tag, "_rf_we"},       32'(rf_we), 0);
        check({tag, "_rf_addr"},     32'(rf_addr), 0);
        check({tag, "_rf_wdata"},    32'(rf_wdata), 0);
        check({tag, "_wb_ack"},      32'(wb_ack_out), 0);
        check({tag, "_ext_ack"},     32'(ext_ack), 0);
        check({tag, "_wb_data"},     wb_data_out, 0);
        check({tag, "_ext_rdata"},   32'(ext_rdata), 0);
        check({tag, "_irq"},         32'(irq_out), 0);
        check({tag, "_ext_irq"},     32'(ext_irq_out), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //            ext  we   addr           wdata  exp    irq  eirq
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_000C, 8'h5A, 8'h5A, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_000C, 8'h00, 8'h5A, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'h0000_0007, 8'h11, 8'h11, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0000_0018, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_001C, 8'h00, 8'h11, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0018, 8'h22, 8'h22, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0003, 8'h00, 8'h5A, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0006, 8'h00, 8'h22, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_0002, 8'hC3, 8'hC3, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'hFFFF_FFE8, 8'h00, 8'hC3, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_001C, 8'h00, 8'h11, 1'b0, 1'b0};

        reset_b = 1'b0;
        wb_cyc_in = 1'b0; wb_stb_in = 1'b0; wb_we_in = 1'b0;
        wb_addr_in = 32'd0; wb_data_in = 32'd0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = 3'd0; ext_wdata = 8'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_b = 1'b1;

        // Tie straight out of reset: WB first, EXT three cycles later.
        t0 = cyc_cnt;
        sb.push_back('{1'b0, 8'h10});
        sb.push_back('{1'b1, 8'h20});
        fork
            wb_access(1'b1, 32'h0000_0000, 8'h10, a1);
            ext_access(1'b1, 3'd1, 8'h20, a2);
        join
        check("tie_wb_ack_cycle", 32'(a1 - t0), 2);
        check("tie_ext_ack_cycle", 32'(a2 - t0), 5);
        @(negedge clk);

        // Register-file strobe timing for a WB write of 0x5A to reg 3.
        sb.push_back('{1'b0, 8'h5A});
        wb_cyc_in = 1'b1; wb_stb_in = 1'b1; wb_we_in = 1'b1;
        wb_addr_in = 32'h0000_000C; wb_data_in = 32'h1234_565A;
        @(negedge clk);
        check("wr_rf_en",    32'(rf_en), 1);
        check("wr_rf_we",    32'(rf_we), 1);
        check("wr_rf_addr",  32'(rf_addr), 3);
        check("wr_rf_wdata", 32'(rf_wdata), 32'h5A);
        check("wr_no_early_ack", 32'(wb_ack_out), 0);
        @(negedge clk);
        check("wr_ack", 32'(wb_ack_out), 1);
        check("wr_rf_en_low", 32'(rf_en), 0);
        wb_cyc_in = 1'b0; wb_stb_in = 1'b0;
        @(negedge clk);
        check("wr_ack_one_cycle", 32'(wb_ack_out), 0);
        sb.push_back('{1'b0, 8'h5A});
        wb_access(1'b0, 32'h0000_000C, 8'h00, a1);
        check("rd_wb_data", wb_data_out, 32'h0000_005A);
        @(negedge clk);

        // WB was served last, so the next tie goes to EXT.
        t0 = cyc_cnt;
        sb.push_back('{1'b1, 8'h33});
        sb.push_back('{1'b0, 8'h44});
        fork
            wb_access(1'b1, 32'h0000_0004, 8'h44, a1);
            ext_access(1'b1, 3'd0, 8'h33, a2);
        join
        check("tie2_ext_ack_cycle", 32'(a2 - t0), 2);
        check("tie2_wb_ack_cycle", 32'(a1 - t0), 5);
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            sb.push_back('{vecs[v].is_ext, vecs[v].exp_data});
            if (vecs[v].is_ext) ext_access(vecs[v].we, vecs[v].addr[2:0], vecs[v].wdata, a1);
            else                wb_access(vecs[v].we, vecs[v].addr, vecs[v].wdata, a1);
            @(negedge clk);
            check($sformatf("vec%0d_irq", v), 32'(irq_out), 32'(vecs[v].exp_irq));
            check($sformatf("vec%0d_ext_irq", v), 32'(ext_irq_out), 32'(vecs[v].exp_ext_irq));
            if (vecs[v].is_ext) check($sformatf("vec%0d_hold", v), 32'(ext_rdata), 32'(vecs[v].exp_data));
            else                check($sformatf("vec%0d_hold", v), wb_data_out, 32'(vecs[v].exp_data));
        end

        // Both sides held for 12 accesses: strict alternation, ack every 3 cycles.
        t0 = cyc_cnt;
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{1'b1, 8'(8'h40 + i)});
            sb.push_back('{1'b0, 8'(8'h50 + i)});
        end
        fork
            begin
                for (int i = 0; i < 6; i++) ext_access(1'b1, 3'd4, 8'(8'h40 + i), ext_at[i]);
            end
            begin
                for (int j = 0; j < 6; j++) wb_access(1'b1, 32'h0000_0014, 8'(8'h50 + j), wb_at[j]);
            end
        join
        for (int i = 0; i < 6; i++) begin
            check($sformatf("alt_ext%0d_cycle", i), 32'(ext_at[i] - t0), 32'(2 + 6 * i));
            check($sformatf("alt_wb%0d_cycle", i),  32'(wb_at[i] - t0),  32'(5 + 6 * i));
        end
        @(negedge clk);

        // Ring both doorbells so the mid-transaction reset has state to clear.
        sb.push_back('{1'b1, 8'h77});
        ext_access(1'b1, 3'd7, 8'h77, a1);
        sb.push_back('{1'b0, 8'h66});
        wb_access(1'b1, 32'h0000_0018, 8'h66, a1);
        @(negedge clk);
        check("pre_rst_irq", 32'(irq_out), 1);
        check("pre_rst_ext_irq", 32'(ext_irq_out), 1);

        // Reset while in ACCESS: transaction abandoned, request re-granted afterwards.
        wb_cyc_in = 1'b1; wb_stb_in = 1'b1; wb_we_in = 1'b0;
        wb_addr_in = 32'h0000_000C; wb_data_in = 32'd0;
        @(negedge clk);
        check("rst_in_access_rf_en", 32'(rf_en), 1);
        reset_b = 1'b0;
        @(negedge clk);
        check_all_zero("rst_access");
        reset_b = 1'b1;
        t0 = cyc_cnt;
        sb.push_back('{1'b0, 8'h5A});
        wb_access(1'b0, 32'h0000_000C, 8'h00, a1);
        check("regrant_ack_cycle", 32'(a1 - t0), 2);
        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
